// File: rtl/muldiv_pkg.sv
// Shared types and constants for the multiply/divide sequencer.
// MULDIV_SIGNED_EN adds the FIXUP state used by signed operations.
package muldiv_pkg;

  localparam int   MULDIV_WIDTH = 32;
  localparam logic MD_MUL       = 1'b0;
  localparam logic MD_DIV       = 1'b1;
  // Replicated WIDTH times to form the divide-by-zero LO value (all ones).
  localparam logic MD_DBZ_FILL  = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BUSY  = 2'd1,
    ST_DONE  = 2'd2
`ifdef MULDIV_SIGNED_EN
    , ST_FIXUP = 2'd3
`endif
  } md_state_e;

endpackage

// File: rtl/muldiv_step.sv
// One combinational iteration: radix-2 shift-add multiply or restoring
// shift-subtract divide over the {acc, lo} working pair.
module muldiv_step
  import muldiv_pkg::*;
#(
  parameter int WIDTH = MULDIV_WIDTH
) (
  input  logic             op,
  input  logic [WIDTH:0]   acc,
  input  logic [WIDTH-1:0] lo,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH:0]   acc_nxt,
  output logic [WIDTH-1:0] lo_nxt
);

  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   rem_sh;
  logic [WIDTH+1:0] trial;

  always_comb begin
    sum    = acc + (lo[0] ? {1'b0, a} : '0);
    rem_sh = {acc[WIDTH-1:0], lo[WIDTH-1]};
    // Top bit of trial is the borrow: set means the divisor did not fit.
    trial  = {1'b0, rem_sh} - {2'b00, b};
    if (op == MD_MUL) begin
      acc_nxt = {1'b0, sum[WIDTH:1]};
      lo_nxt  = {sum[0], lo[WIDTH-1:1]};
    end else if (!trial[WIDTH+1]) begin
      acc_nxt = trial[WIDTH:0];
      lo_nxt  = {lo[WIDTH-2:0], 1'b1};
    end else begin
      acc_nxt = rem_sh;
      lo_nxt  = {lo[WIDTH-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/ex_muldiv_ctrl.sv
// Execute-stage multiply/divide sequencer owning HI/LO; stalls via obusy.
// Define MULDIV_SIGNED_EN to enable signed MULT/DIV through a FIXUP cycle.
module ex_muldiv_ctrl
  import muldiv_pkg::*;
#(
  parameter int WIDTH = MULDIV_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             istart,
  input  logic             iop,
  input  logic             isigned,
  input  logic [WIDTH-1:0] iA,
  input  logic [WIDTH-1:0] iB,
  input  logic             iflush,
  output logic             obusy,
  output logic             odone,
  output logic             odiv_by_zero,
  output logic [WIDTH-1:0] ohi,
  output logic [WIDTH-1:0] olo
);

  localparam int            CW        = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST_STEP = CW'(WIDTH - 1);

  md_state_e        state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, low_q, low_d, hi_q, hi_d, lo_q, lo_d;
  logic [WIDTH:0]   acc_q, acc_d;
  logic             op_q, op_d, dbz_q, dbz_d, done_q, done_d, dbz_out_q, dbz_out_d;
  logic [WIDTH:0]   step_acc;
  logic [WIDTH-1:0] step_lo;

`ifdef MULDIV_SIGNED_EN
  logic               sgn_q, sgn_d, neg_res_q, neg_res_d, neg_rem_q, neg_rem_d;
  logic [2*WIDTH-1:0] prod_fix;
`else
  logic unused_isigned;
  assign unused_isigned = isigned;
`endif

  muldiv_step #(.WIDTH(WIDTH)) u_step (
    .op      (op_q),
    .acc     (acc_q),
    .lo      (low_q),
    .a       (a_q),
    .b       (b_q),
    .acc_nxt (step_acc),
    .lo_nxt  (step_lo)
  );

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    a_d       = a_q;
    b_d       = b_q;
    acc_d     = acc_q;
    low_d     = low_q;
    op_d      = op_q;
    dbz_d     = dbz_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    done_d    = 1'b0;
    dbz_out_d = 1'b0;
    obusy     = 1'b0;
`ifdef MULDIV_SIGNED_EN
    sgn_d     = sgn_q;
    neg_res_d = neg_res_q;
    neg_rem_d = neg_rem_q;
    prod_fix  = '0;
`endif
    case (state_q)
      ST_IDLE: begin
        // Stall the issuing instruction in the same cycle it asks to start.
        obusy = istart && !iflush && !rst;
        if (istart && !iflush) begin
          op_d  = iop;
          cnt_d = '0;
          acc_d = '0;
          a_d   = iA;
          b_d   = iB;
          dbz_d = 1'b0;
`ifdef MULDIV_SIGNED_EN
          sgn_d     = isigned;
          neg_res_d = isigned & (iA[WIDTH-1] ^ iB[WIDTH-1]);
          neg_rem_d = isigned & iA[WIDTH-1];
          if (isigned && iA[WIDTH-1]) a_d = -iA;
          if (isigned && iB[WIDTH-1]) b_d = -iB;
`endif
          low_d = (iop == MD_MUL) ? b_d : a_d;
          if (iop == MD_DIV && iB == '0) begin
            dbz_d   = 1'b1;
            a_d     = iA;
            state_d = ST_DONE;
          end else begin
            state_d = ST_BUSY;
          end
        end
      end
      ST_BUSY: begin
        obusy = 1'b1;
        acc_d = step_acc;
        low_d = step_lo;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == LAST_STEP) begin
`ifdef MULDIV_SIGNED_EN
          state_d = sgn_q ? ST_FIXUP : ST_DONE;
`else
          state_d = ST_DONE;
`endif
        end
      end
`ifdef MULDIV_SIGNED_EN
      ST_FIXUP: begin
        obusy = 1'b1;
        if (op_q == MD_MUL) begin
          prod_fix = {acc_q[WIDTH-1:0], low_q};
          if (neg_res_q) prod_fix = -prod_fix;
          acc_d = {1'b0, prod_fix[2*WIDTH-1:WIDTH]};
          low_d = prod_fix[WIDTH-1:0];
        end else begin
          if (neg_res_q) low_d = -low_q;
          if (neg_rem_q) acc_d = {1'b0, -acc_q[WIDTH-1:0]};
        end
        state_d = ST_DONE;
      end
`endif
      ST_DONE: begin
        done_d    = 1'b1;
        dbz_out_d = dbz_q;
        hi_d      = dbz_q ? a_q : acc_q[WIDTH-1:0];
        lo_d      = dbz_q ? {WIDTH{MD_DBZ_FILL}} : low_q;
        state_d   = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    // A squash abandons any operation and leaves HI/LO untouched.
    if (iflush) begin
      state_d   = ST_IDLE;
      hi_d      = hi_q;
      lo_d      = lo_q;
      done_d    = 1'b0;
      dbz_out_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      a_q       <= '0;
      b_q       <= '0;
      acc_q     <= '0;
      low_q     <= '0;
      op_q      <= 1'b0;
      dbz_q     <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
      done_q    <= 1'b0;
      dbz_out_q <= 1'b0;
`ifdef MULDIV_SIGNED_EN
      sgn_q     <= 1'b0;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      a_q       <= a_d;
      b_q       <= b_d;
      acc_q     <= acc_d;
      low_q     <= low_d;
      op_q      <= op_d;
      dbz_q     <= dbz_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      done_q    <= done_d;
      dbz_out_q <= dbz_out_d;
`ifdef MULDIV_SIGNED_EN
      sgn_q     <= sgn_d;
      neg_res_q <= neg_res_d;
      neg_rem_q <= neg_rem_d;
`endif
    end
  end

  assign ohi          = hi_q;
  assign olo          = lo_q;
  assign odone        = done_q;
  assign odiv_by_zero = dbz_out_q;

endmodule

// File: tb/tb_ex_muldiv_ctrl.sv
// Directed testbench for ex_muldiv_ctrl: multiply, divide, divide-by-zero,
// flush, async reset, back-to-back and (with MULDIV_SIGNED_EN) signed ops.
module tb_ex_muldiv_ctrl;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst, istart, iop, isigned, iflush;
  logic [W-1:0] iA, iB;
  logic         obusy, odone, odiv_by_zero;
  logic [W-1:0] ohi, olo;

  int checks = 0;
  int errors = 0;

  ex_muldiv_ctrl #(.WIDTH(W)) dut (
    .clk          (clk),
    .rst          (rst),
    .istart       (istart),
    .iop          (iop),
    .isigned      (isigned),
    .iA           (iA),
    .iB           (iB),
    .iflush       (iflush),
    .obusy        (obusy),
    .odone        (odone),
    .odiv_by_zero (odiv_by_zero),
    .ohi          (ohi),
    .olo          (olo)
  );

  always #5 clk = ~clk;

  // Issues one op and waits (bounded) for odone; edges counted after the start edge.
  task automatic run_op(input logic op, input logic sgn, input logic [W-1:0] a,
                        input logic [W-1:0] b, output int edges, output int busy_cyc);
    iop = op; isigned = sgn; iA = a; iB = b; istart = 1'b1;
    busy_cyc = 0;
    #1;
    if (obusy) busy_cyc++;
    @(posedge clk); #1;
    istart = 1'b0;
    edges = 0;
    while (!odone && edges < 200) begin
      if (obusy) busy_cyc++;
      @(posedge clk); #1;
      edges++;
    end
    $display("txn op=%0d sgn=%0d a=%h b=%h -> hi=%h lo=%h dbz=%0d edges=%0d busy=%0d",
             op, sgn, a, b, ohi, olo, odiv_by_zero, edges, busy_cyc);
  endtask

  task automatic test_reset();
    rst = 1'b1; istart = 1'b0; iop = 1'b0; isigned = 1'b0; iflush = 1'b0;
    iA = '0; iB = '0;
    #1;
    checks++; if (ohi !== '0) begin errors++; $display("FAIL reset_hi got %h want 0", ohi); end
    checks++; if (olo !== '0) begin errors++; $display("FAIL reset_lo got %h want 0", olo); end
    checks++; if (obusy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", obusy); end
    checks++; if (odone !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", odone); end
    repeat (2) @(posedge clk);
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    $display("txn reset released");
  endtask

  task automatic test_multu();
    int e, bc;
    run_op(1'b0, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, e, bc);
    checks++; if (e !== 33) begin errors++; $display("FAIL multu_latency got %0d want 33", e); end
    checks++; if (bc !== 33) begin errors++; $display("FAIL multu_busy_cycles got %0d want 33", bc); end
    checks++; if (ohi !== 32'hFFFF_FFFE) begin errors++; $display("FAIL multu_hi got %h want fffffffe", ohi); end
    checks++; if (olo !== 32'h0000_0001) begin errors++; $display("FAIL multu_lo got %h want 00000001", olo); end
    checks++; if (odiv_by_zero !== 1'b0) begin errors++; $display("FAIL multu_dbz got %b want 0", odiv_by_zero); end
    @(posedge clk); #1;
    checks++; if (odone !== 1'b0) begin errors++; $display("FAIL multu_done_pulse got %b want 0", odone); end
  endtask

  task automatic test_divu();
    int e, bc;
    run_op(1'b1, 1'b0, 32'd100, 32'd7, e, bc);
    checks++; if (e !== 33) begin errors++; $display("FAIL divu_latency got %0d want 33", e); end
    checks++; if (olo !== 32'd14) begin errors++; $display("FAIL divu_lo got %h want 0000000e", olo); end
    checks++; if (ohi !== 32'd2) begin errors++; $display("FAIL divu_hi got %h want 00000002", ohi); end
    checks++; if (odiv_by_zero !== 1'b0) begin errors++; $display("FAIL divu_dbz got %b want 0", odiv_by_zero); end
  endtask

  task automatic test_div_zero();
    int e, bc;
    run_op(1'b1, 1'b0, 32'd5, 32'd0, e, bc);
    checks++; if (e !== 1) begin errors++; $display("FAIL dbz_latency got %0d want 1", e); end
    checks++; if (bc !== 1) begin errors++; $display("FAIL dbz_busy_cycles got %0d want 1", bc); end
    checks++; if (odiv_by_zero !== 1'b1) begin errors++; $display("FAIL dbz_flag got %b want 1", odiv_by_zero); end
    checks++; if (ohi !== 32'd5) begin errors++; $display("FAIL dbz_hi got %h want 00000005", ohi); end
    checks++; if (olo !== 32'hFFFF_FFFF) begin errors++; $display("FAIL dbz_lo got %h want ffffffff", olo); end
    @(posedge clk); #1;
    checks++; if (odiv_by_zero !== 1'b0) begin errors++; $display("FAIL dbz_flag_pulse got %b want 0", odiv_by_zero); end
    checks++; if (obusy !== 1'b0) begin errors++; $display("FAIL dbz_busy_after got %b want 0", obusy); end
  endtask

  task automatic test_flush();
    int e, bc, seen;
    // 0x246B975 = 0x2222 * 0x1112 + 0x1111 preloads HI/LO
    run_op(1'b1, 1'b0, 32'h0246_B975, 32'h0000_1112, e, bc);
    checks++; if (ohi !== 32'h1111) begin errors++; $display("FAIL preload_hi got %h want 00001111", ohi); end
    checks++; if (olo !== 32'h2222) begin errors++; $display("FAIL preload_lo got %h want 00002222", olo); end
    iop = 1'b0; iA = 32'd3; iB = 32'd4; istart = 1'b1;
    @(posedge clk); #1;
    istart = 1'b0;
    repeat (10) @(posedge clk);
    #1; iflush = 1'b1;
    @(posedge clk); #1;
    iflush = 1'b0;
    checks++; if (obusy !== 1'b0) begin errors++; $display("FAIL flush_busy got %b want 0", obusy); end
    seen = 0;
    repeat (40) begin
      if (odone) seen++;
      @(posedge clk); #1;
    end
    checks++; if (seen !== 0) begin errors++; $display("FAIL flush_no_done got %0d pulses want 0", seen); end
    checks++; if (ohi !== 32'h1111) begin errors++; $display("FAIL flush_hi got %h want 00001111", ohi); end
    checks++; if (olo !== 32'h2222) begin errors++; $display("FAIL flush_lo got %h want 00002222", olo); end
    $display("txn flush mid-multiply hi=%h lo=%h", ohi, olo);
    // start and flush together in IDLE: no start
    istart = 1'b1; iflush = 1'b1; iop = 1'b0;
    #1;
    checks++; if (obusy !== 1'b0) begin errors++; $display("FAIL flush_start_busy got %b want 0", obusy); end
    @(posedge clk); #1;
    istart = 1'b0; iflush = 1'b0;
    seen = 0;
    repeat (40) begin
      if (odone || obusy) seen++;
      @(posedge clk); #1;
    end
    checks++; if (seen !== 0) begin errors++; $display("FAIL flush_wins got %0d active cycles want 0", seen); end
    $display("txn start+flush in idle ignored");
    run_op(1'b0, 1'b0, 32'd3, 32'd4, e, bc);
    checks++; if (e !== 33) begin errors++; $display("FAIL post_flush_latency got %0d want 33", e); end
    checks++; if (ohi !== 32'd0) begin errors++; $display("FAIL post_flush_hi got %h want 0", ohi); end
    checks++; if (olo !== 32'd12) begin errors++; $display("FAIL post_flush_lo got %h want 0000000c", olo); end
  endtask

  task automatic test_back_to_back();
    int e, bc;
    run_op(1'b0, 1'b0, 32'h0001_0000, 32'h0001_0000, e, bc);
    checks++; if (ohi !== 32'd1 || olo !== 32'd0) begin
      errors++; $display("FAIL b2b_mul got %h_%h want 00000001_00000000", ohi, olo);
    end
    run_op(1'b1, 1'b0, 32'hFFFF_FFFF, 32'h10, e, bc);
    checks++; if (e !== 33) begin errors++; $display("FAIL b2b_div_latency got %0d want 33", e); end
    checks++; if (ohi !== 32'hF || olo !== 32'h0FFF_FFFF) begin
      errors++; $display("FAIL b2b_div got %h_%h want 0000000f_0fffffff", ohi, olo);
    end
    // start pulse mid-operation must be ignored
    iop = 1'b1; iA = 32'd1000; iB = 32'd10; istart = 1'b1;
    @(posedge clk); #1;
    istart = 1'b0;
    repeat (5) @(posedge clk);
    #1; iop = 1'b0; iA = 32'd7; iB = 32'd9; istart = 1'b1;
    @(posedge clk); #1;
    istart = 1'b0;
    e = 6;
    while (!odone && e < 200) begin
      @(posedge clk); #1;
      e++;
    end
    $display("txn div 1000/10 with ignored start -> hi=%h lo=%h edges=%0d", ohi, olo, e);
    checks++; if (e !== 33) begin errors++; $display("FAIL ignore_start_latency got %0d want 33", e); end
    checks++; if (ohi !== 32'd0 || olo !== 32'd100) begin
      errors++; $display("FAIL ignore_start got %h_%h want 00000000_00000064", ohi, olo);
    end
  endtask

  task automatic test_async_reset();
    iop = 1'b0; iA = 32'd9; iB = 32'd9; istart = 1'b1;
    @(posedge clk); #1;
    istart = 1'b0;
    repeat (5) @(posedge clk);
    #3 rst = 1'b1;
    #1;
    checks++; if (ohi !== '0 || olo !== '0) begin
      errors++; $display("FAIL async_rst_hilo got %h_%h want 0_0", ohi, olo);
    end
    checks++; if (obusy !== 1'b0) begin errors++; $display("FAIL async_rst_busy got %b want 0", obusy); end
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    checks++; if (obusy !== 1'b0 || odone !== 1'b0) begin
      errors++; $display("FAIL async_rst_idle got busy=%b done=%b want 0 0", obusy, odone);
    end
    $display("txn async reset mid-busy hi=%h lo=%h", ohi, olo);
  endtask

  task automatic test_signed();
    int e, bc;
`ifdef MULDIV_SIGNED_EN
    run_op(1'b0, 1'b1, -32'sd3, 32'sd5, e, bc);
    checks++; if (e !== 34) begin errors++; $display("FAIL mult_latency got %0d want 34", e); end
    checks++; if (ohi !== 32'hFFFF_FFFF || olo !== 32'hFFFF_FFF1) begin
      errors++; $display("FAIL mult_neg got %h_%h want ffffffff_fffffff1", ohi, olo);
    end
    run_op(1'b1, 1'b1, -32'sd7, 32'sd2, e, bc);
    checks++; if (e !== 34) begin errors++; $display("FAIL div_latency got %0d want 34", e); end
    checks++; if (ohi !== 32'hFFFF_FFFF || olo !== 32'hFFFF_FFFD) begin
      errors++; $display("FAIL div_neg got %h_%h want ffffffff_fffffffd", ohi, olo);
    end
    run_op(1'b1, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, e, bc);
    checks++; if (ohi !== 32'h0 || olo !== 32'h8000_0000) begin
      errors++; $display("FAIL div_overflow got %h_%h want 00000000_80000000", ohi, olo);
    end
`else
    // isigned ignored: 0xFFFFFFFD * 5 = 0x4_FFFFFFF1
    run_op(1'b0, 1'b1, 32'hFFFF_FFFD, 32'd5, e, bc);
    checks++; if (e !== 33) begin errors++; $display("FAIL unsigned_only_latency got %0d want 33", e); end
    checks++; if (ohi !== 32'h4 || olo !== 32'hFFFF_FFF1) begin
      errors++; $display("FAIL unsigned_only got %h_%h want 00000004_fffffff1", ohi, olo);
    end
`endif
  endtask

  initial begin
    test_reset();
    test_multu();
    test_divu();
    test_div_zero();
    test_flush();
    test_back_to_back();
    test_async_reset();
    test_signed();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
